// File: rtl/led_sequencer.sv
// Replays a CPU-loaded LED pattern table into the LED PIO data register via an Avalon-MM master.
// Latency: bus write appears the cycle after RUN is registered; steps are PERIOD+1 cycles apart.
// Backpressure: m_waitrequest holds the pending write (and the step timer) until it is accepted.
//
// Ports: clk/reset_n (sync, active low); CSR slave address/chipselect/write_n/writedata/readdata;
//        PIO master m_address/m_chipselect/m_write_n/m_writedata/m_waitrequest; irq (level).
// Optional feature: define LED_SEQ_IRQ_EN to add CONTROL bit2 IRQ_EN and a registered DONE interrupt.
module led_sequencer #(
  parameter int DEPTH    = 8,
  parameter int PERIOD_W = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest,
  output logic        irq
);

  localparam int IW = $clog2(DEPTH);
  localparam int LW = IW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_WAIT} state_e;

  // CSR state
  logic                run_q, loop_q, done_q;
  logic [PERIOD_W-1:0] period_q;
  logic [LW-1:0]       length_q;
  logic [IW-1:0]       ptr_q;
  logic [7:0]          table_q [DEPTH];

  // Sequencer state
  state_e              state_q, state_d;
  logic [IW-1:0]       index_q, index_d;
  logic [PERIOD_W-1:0] timer_q, timer_d;
  logic                finish;

  // Registered master outputs
  logic                m_cs_q, m_cs_d;
  logic [7:0]          m_pat_q, m_pat_d;

  logic                irq_en_rd;
  logic                unused_wd;

  // CSR write decode
  logic csr_wr, wr_ctrl, wr_status, wr_period, wr_length, wr_ptr, wr_data;
  assign csr_wr    = chipselect && !write_n;
  assign wr_ctrl   = csr_wr && (address == 3'd0);
  assign wr_status = csr_wr && (address == 3'd1);
  assign wr_period = csr_wr && (address == 3'd2);
  assign wr_length = csr_wr && (address == 3'd3);
  assign wr_ptr    = csr_wr && (address == 3'd4);
  assign wr_data   = csr_wr && (address == 3'd5);
  assign unused_wd = ^writedata;

  // Effective period/length: 0 behaves as 1, LENGTH saturates at DEPTH
  logic [PERIOD_W-1:0] period_eff;
  logic [LW-1:0]       length_eff;
  logic [LW-1:0]       next_idx;
  assign period_eff = (period_q == '0) ? PERIOD_W'(1) : period_q;
  assign length_eff = (length_q == '0)         ? LW'(1)     :
                      (length_q > LW'(DEPTH))  ? LW'(DEPTH) : length_q;
  assign next_idx   = {1'b0, index_q} + LW'(1);

  // FSM: state register (also registers the master outputs)
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      timer_q <= '0;
      m_cs_q  <= 1'b0;
      m_pat_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      timer_q <= timer_d;
      m_cs_q  <= m_cs_d;
      m_pat_q <= m_pat_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    timer_d = timer_q;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run_q) begin
          state_d = ST_WRITE;
          index_d = '0;
        end
      end
      ST_WRITE: begin
        // A stop request never abandons a write the bus has not accepted yet
        if (!m_waitrequest) begin
          if (run_q) begin
            state_d = ST_WAIT;
            timer_d = period_eff - PERIOD_W'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT: begin
        if (!run_q) begin
          state_d = ST_IDLE;
        end else if (timer_q == '0) begin
          if (next_idx < length_eff) begin
            state_d = ST_WRITE;
            index_d = next_idx[IW-1:0];
          end else if (loop_q) begin
            state_d = ST_WRITE;
            index_d = '0;
          end else begin
            state_d = ST_IDLE;
            finish  = 1'b1;
          end
        end else begin
          timer_d = timer_q - PERIOD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: output logic; the pattern is captured only on entry to WRITE so a
  // stalled write keeps stable data and table edits land on the next issue.
  always_comb begin
    m_cs_d  = (state_d == ST_WRITE);
    m_pat_d = m_pat_q;
    if (state_d == ST_WRITE && state_q != ST_WRITE) begin
      m_pat_d = table_q[index_d];
    end
  end

  assign m_address    = 2'b00;
  assign m_chipselect = m_cs_q;
  assign m_write_n    = !m_cs_q;
  assign m_writedata  = {24'b0, m_pat_q};

  // CSR registers and pattern table
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run_q    <= 1'b0;
      loop_q   <= 1'b0;
      done_q   <= 1'b0;
      period_q <= PERIOD_W'(1);
      length_q <= LW'(DEPTH);
      ptr_q    <= '0;
      for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
    end else begin
      if (wr_ctrl) begin
        run_q  <= writedata[0];
        loop_q <= writedata[1];
      end
      // Natural completion overrides a simultaneous RUN=1 write
      if (finish) run_q <= 1'b0;

      // DONE set wins over a simultaneous clear
      if (wr_status && writedata[1]) done_q <= 1'b0;
      if (finish) done_q <= 1'b1;

      if (wr_period) period_q <= writedata[PERIOD_W-1:0];
      if (wr_length) length_q <= writedata[LW-1:0];
      if (wr_ptr)    ptr_q    <= writedata[IW-1:0];
      if (wr_data) begin
        table_q[ptr_q] <= writedata[7:0];
        ptr_q          <= ptr_q + IW'(1);  // DEPTH is a power of two, so this wraps
      end
    end
  end

`ifdef LED_SEQ_IRQ_EN
  logic irq_en_q, irq_q;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en_q <= writedata[2];
      irq_q <= done_q && irq_en_q;
    end
  end
  assign irq_en_rd = irq_en_q;
  assign irq       = irq_q;
`else
  assign irq_en_rd = 1'b0;
  assign irq       = 1'b0;
`endif

  // CSR read mux, zero wait states
  logic [3:0] idx4;
  always_comb begin
    idx4         = '0;
    idx4[IW-1:0] = index_q;
  end

  always_comb begin
    readdata = '0;
    case (address)
      3'd0: readdata = {29'b0, irq_en_rd, loop_q, run_q};
      3'd1: readdata = {20'b0, idx4, 6'b0, done_q, (state_q != ST_IDLE)};
      3'd2: readdata = 32'(period_q);
      3'd3: readdata = 32'(length_q);
      3'd4: readdata = 32'(ptr_q);
      3'd5: readdata = {24'b0, table_q[ptr_q]};
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: expected PIO writes (pattern + spacing) queued at stimulus time,
// popped by a negedge monitor on each accepted write.
module tb_led_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic        m_waitrequest;
  logic        irq;

  logic stall_wr = 1'b0;
  logic hold_wr  = 1'b0;
  assign m_waitrequest = stall_wr | hold_wr;

  led_sequencer #(.DEPTH(8), .PERIOD_W(24)) dut (
    .clk(clk), .reset_n(reset_n),
    .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .m_waitrequest(m_waitrequest), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         gap;   // cycles since previous acceptance; 0 = not checked
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  int   last_acc = 0;
  int   extra = 0;
  int   stall_at = -1;
  int   stall_left = 0;
  logic stalled_once = 1'b0;
  logic irq_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: injects one 3-cycle stall, scores accepted writes
  always @(negedge clk) begin
    exp_t e;
    if (stall_left > 0) begin
      chk("stall_hold", {30'b0, m_chipselect, m_write_n}, 32'h2);
      stall_left--;
      if (stall_left == 0) stall_wr = 1'b0;
    end else if (!stalled_once && acc_cnt == stall_at && m_chipselect && !m_write_n) begin
      stall_wr     = 1'b1;
      stall_left   = 3;
      stalled_once = 1'b1;
    end
    if (reset_n && m_chipselect && !m_write_n && !(stall_wr | hold_wr)) begin
      acc_cnt++;
      if (exp_q.size() == 0) begin
        extra++;
      end else begin
        e = exp_q.pop_front();
        chk("wdata", m_writedata, {24'b0, e.d});
        if (e.gap != 0) chk("gap", cyc - last_acc, e.gap);
      end
      last_acc = cyc;
    end
`ifndef LED_SEQ_IRQ_EN
    if (irq !== 1'b0) irq_seen = 1'b1;
`endif
  end

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input int gap);
    exp_t e;
    e.d = d; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic wait_acc(input int target);
    for (int i = 0; i < 500; i++) begin
      if (acc_cnt >= target) break;
      @(posedge clk);
    end
    chk("acc_count", acc_cnt, target);
  endtask

  task automatic wait_idle(output logic [31:0] st);
    st = 32'hFFFF_FFFF;
    for (int i = 0; i < 200; i++) begin
      csr_rd(3'd1, st);
      if (!st[0]) break;
    end
  endtask

  task automatic chk_reset_csrs();
    logic [31:0] exp_vals [8];
    logic [31:0] rd;
    exp_vals = '{32'd0, 32'd0, 32'd1, 32'd8, 32'd0, 32'd0, 32'd0, 32'd0};
    for (int a = 0; a < 8; a++) begin
      csr_rd(3'(a), rd);
      chk($sformatf("rst_csr%0d", a), rd, exp_vals[a]);
    end
    chk("rst_m_wn", {31'b0, m_write_n}, 32'd1);
    chk("rst_m_cs", {31'b0, m_chipselect}, 32'd0);
    chk("rst_m_wd", m_writedata, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int base;
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state
    chk_reset_csrs();

    // One-shot sequence 0x01,0x02,0x04 with PERIOD=4
    csr_wr(3'd4, 32'd0);
    csr_wr(3'd5, 32'h01);
    csr_wr(3'd5, 32'h02);
    csr_wr(3'd5, 32'h04);
    csr_wr(3'd3, 32'd3);
    csr_wr(3'd2, 32'd4);
    push(8'h01, 0); push(8'h02, 5); push(8'h04, 5);
    csr_wr(3'd0, 32'h1);
    chk("start_pre", {31'b0, m_chipselect}, 32'd0);
    @(posedge clk); #1;
    chk("start_lat", {31'b0, m_chipselect}, 32'd1);
    wait_acc(3);
    wait_idle(rd);
    chk("oneshot_status", rd, 32'h0000_0202);
    csr_rd(3'd0, rd);
    chk("oneshot_ctrl", rd, 32'h0);
    chk("oneshot_hold", m_writedata, 32'h04);
    csr_wr(3'd1, 32'h2);
    csr_rd(3'd1, rd);
    chk("done_clear", rd, 32'h0000_0200);

    // LOOP with a 3-cycle stall on the second write, then stop during WAIT
    base = acc_cnt;
    stall_at = base + 1;
    push(8'h01, 0); push(8'h02, 8); push(8'h04, 5);
    push(8'h01, 5); push(8'h02, 5); push(8'h04, 5);
    csr_wr(3'd0, 32'h3);
    wait_acc(base + 6);
    csr_wr(3'd0, 32'h0);
    @(posedge clk); #1;
    csr_rd(3'd1, rd);
    chk("stop_status", rd, 32'h0000_0200);
    repeat (20) @(posedge clk);
    chk("stop_extra", extra, 0);
    chk("stop_queue", exp_q.size(), 0);

    // Reset while a write is stalled
    hold_wr = 1'b1;
    csr_wr(3'd0, 32'h1);
    @(posedge clk); #1;
    chk("hold_cs", {31'b0, m_chipselect}, 32'd1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_cs", {31'b0, m_chipselect}, 32'd0);
    reset_n = 1'b1;
    hold_wr = 1'b0;
    chk_reset_csrs();

    // LENGTH=0, PERIOD=0: one write, DONE after a single WAIT cycle
    csr_wr(3'd5, 32'h5A);
    csr_wr(3'd3, 32'd0);
    csr_wr(3'd2, 32'd0);
    csr_rd(3'd3, rd);
    chk("len0_rb", rd, 32'd0);
    push(8'h5A, 0);
    csr_wr(3'd0, 32'h5);
    address = 3'd1; chipselect = 1'b1; write_n = 1'b1;
    @(posedge clk); #1;
    chk("b0_write_cs", {31'b0, m_chipselect}, 32'd1);
    chk("b0_write_st", readdata, 32'h1);
    @(posedge clk); #1;
    chk("b0_wait_cs", {31'b0, m_chipselect}, 32'd0);
    chk("b0_wait_st", readdata, 32'h1);
    @(posedge clk); #1;
    chk("b0_done_st", readdata, 32'h2);
    chk("b0_irq_pre", {31'b0, irq}, 32'd0);
    @(posedge clk); #1;
    address = 3'd0; #1;
`ifdef LED_SEQ_IRQ_EN
    chk("irq_rise", {31'b0, irq}, 32'd1);
    chk("ctrl_irqen", readdata, 32'h4);
`else
    chk("irq_off", {31'b0, irq}, 32'd0);
    chk("ctrl_noirqen", readdata, 32'h0);
`endif
    chipselect = 1'b0;
    csr_wr(3'd1, 32'h2);
    @(posedge clk); #1;
    chk("irq_clear", {31'b0, irq}, 32'd0);
    csr_rd(3'd1, rd);
    chk("b0_cleared", rd, 32'h0);

    // LENGTH=15 clamps to 8; PTR wraps after slot 7
    csr_wr(3'd4, 32'd0);
    for (int i = 0; i < 8; i++) csr_wr(3'd5, 32'h10 + i);
    csr_rd(3'd4, rd);
    chk("ptr_wrap", rd, 32'd0);
    csr_wr(3'd5, 32'hA5);
    csr_rd(3'd4, rd);
    chk("ptr_after", rd, 32'd1);
    csr_rd(3'd5, rd);
    chk("data_rd", rd, 32'h11);
    csr_wr(3'd2, 32'd1);
    csr_wr(3'd3, 32'd15);
    csr_rd(3'd3, rd);
    chk("len15_rb", rd, 32'd15);
    base = acc_cnt;
    push(8'hA5, 0);
    for (int i = 1; i < 8; i++) push(8'(8'h10 + i), 2);
    csr_wr(3'd0, 32'h1);
    wait_acc(base + 8);
    wait_idle(rd);
    chk("len15_status", rd, 32'h0000_0702);
    repeat (10) @(posedge clk);

    chk("final_extra", extra, 0);
    chk("final_queue", exp_q.size(), 0);
`ifndef LED_SEQ_IRQ_EN
    chk("irq_never", {31'b0, irq_seen}, 32'd0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
